// File: rtl/calc_pkg.sv
// Shared constants for the BCD calculator controller: key codes, ALU op codes
// and the controller state encoding.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQ  = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_BS  = 4'hE;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam logic [15:0] BCD_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_ALU = 2'd2,
        SHOW_RES = 2'd3
    } state_e;

    function automatic logic [1:0] key_to_op(input logic [3:0] key);
        return (key == KEY_SUB) ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/calc_ctrl_bcd_entry_reg.sv
// 4-digit BCD operand register with digit count; shifts digits in from the right.
// Backspace support is present only when CALC_BACKSPACE_EN is defined.
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic [2:0]  load_cnt_i,
    input  logic        shift_i,
    input  logic [3:0]  digit_i,
`ifdef CALC_BACKSPACE_EN
    input  logic        bs_i,
`endif
    output logic [15:0] val_o,
    output logic [2:0]  cnt_o
);

    logic [15:0] val_q, val_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        val_d = val_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            val_d = BCD_ZERO;
            cnt_d = 3'd0;
        end else if (load_i) begin
            val_d = load_val_i;
            cnt_d = load_cnt_i;
        end else if (shift_i) begin
            // Leading zeros are swallowed; a full register ignores further digits.
            if (!(val_q == BCD_ZERO && digit_i == 4'd0) && cnt_q != 3'd4) begin
                val_d = {val_q[11:0], digit_i};
                cnt_d = cnt_q + 3'd1;
            end
        end
`ifdef CALC_BACKSPACE_EN
        else if (bs_i && cnt_q != 3'd0) begin
            val_d = {4'h0, val_q[15:4]};
            cnt_d = cnt_q - 3'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= BCD_ZERO;
            cnt_q <= 3'd0;
        end else begin
            val_q <= val_d;
            cnt_q <= cnt_d;
        end
    end

    assign val_o = val_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/calc_ctrl.sv
// Keypad-to-ALU sequencer: builds BCD operands, runs the pipelined ALU, shows results.
// Optional backspace key enabled by defining CALC_BACKSPACE_EN.
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [15:0] alu_num1,
    output logic [15:0] alu_num2,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_result,
    output logic [15:0] disp_bcd,
    output logic        busy
);

    localparam int WCW = $clog2(ALU_LAT + 2);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d, pend_q, pend_d;
    logic             chain_q, chain_d;
    logic [15:0]      last_b_q, last_b_d;
    logic [WCW-1:0]   wait_q, wait_d;

    logic [15:0] a_val, b_val, a_load_val;
    logic [2:0]  a_cnt, b_cnt, a_load_cnt;
    logic        a_clr, a_load, a_shift, b_clr, b_load, b_shift, full_reset;
    logic        key_fire, is_digit, is_op;
`ifdef CALC_BACKSPACE_EN
    logic        a_bs, b_bs;
`endif

    assign key_fire = key_valid && key_ready;
    assign is_digit = key_code <= 4'd9;
    assign is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENTER_A;
            op_q     <= OP_ADD;
            pend_q   <= OP_ADD;
            chain_q  <= 1'b0;
            last_b_q <= BCD_ZERO;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pend_q   <= pend_d;
            chain_q  <= chain_d;
            last_b_q <= last_b_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        pend_d     = pend_q;
        chain_d    = chain_q;
        last_b_d   = last_b_q;
        wait_d     = wait_q;
        a_clr      = 1'b0;
        a_load     = 1'b0;
        a_load_val = BCD_ZERO;
        a_load_cnt = 3'd0;
        a_shift    = 1'b0;
        b_clr      = 1'b0;
        b_load     = 1'b0;
        b_shift    = 1'b0;
        full_reset = 1'b0;
`ifdef CALC_BACKSPACE_EN
        a_bs       = 1'b0;
        b_bs       = 1'b0;
`endif
        case (state_q)
            ENTER_A: if (key_fire) begin
                if (is_digit) a_shift = 1'b1;
                else if (is_op) begin
                    op_d    = key_to_op(key_code);
                    b_clr   = 1'b1;
                    state_d = ENTER_B;
                end else if (key_code == KEY_CLR) a_clr = 1'b1;
`ifdef CALC_BACKSPACE_EN
                else if (key_code == KEY_BS) a_bs = 1'b1;
`endif
            end
            ENTER_B: if (key_fire) begin
                if (is_digit) b_shift = 1'b1;
                else if (is_op && b_cnt == 3'd0) op_d = key_to_op(key_code);
                else if (is_op) begin
                    pend_d  = key_to_op(key_code);
                    chain_d = 1'b1;
                    wait_d  = WCW'(ALU_LAT);
                    state_d = WAIT_ALU;
                end else if (key_code == KEY_EQ) begin
                    chain_d = 1'b0;
                    wait_d  = WCW'(ALU_LAT);
                    state_d = WAIT_ALU;
                end else if (key_code == KEY_CLR) full_reset = 1'b1;
`ifdef CALC_BACKSPACE_EN
                else if (key_code == KEY_BS) b_bs = 1'b1;
`endif
            end
            WAIT_ALU: begin
                // Counter runs ALU_LAT..0, so the result is sampled after ALU_LAT+1 cycles.
                if (wait_q == '0) begin
                    a_load     = 1'b1;
                    a_load_val = alu_result;
                    a_load_cnt = 3'd4;
                    last_b_d   = b_val;
                    if (chain_q) begin
                        op_d    = pend_q;
                        b_clr   = 1'b1;
                        state_d = ENTER_B;
                    end else begin
                        state_d = SHOW_RES;
                    end
                end else begin
                    wait_d = wait_q - WCW'(1);
                end
            end
            SHOW_RES: if (key_fire) begin
                if (is_digit) begin
                    a_load     = 1'b1;
                    a_load_val = {12'h000, key_code};
                    a_load_cnt = (key_code != 4'd0) ? 3'd1 : 3'd0;
                    state_d    = ENTER_A;
                end else if (is_op) begin
                    op_d    = key_to_op(key_code);
                    b_clr   = 1'b1;
                    state_d = ENTER_B;
                end else if (key_code == KEY_EQ) begin
                    b_load  = 1'b1;
                    wait_d  = WCW'(ALU_LAT);
                    state_d = WAIT_ALU;
                end else if (key_code == KEY_CLR) full_reset = 1'b1;
            end
            default: state_d = ENTER_A;
        endcase
        if (full_reset) begin
            state_d  = ENTER_A;
            op_d     = OP_ADD;
            pend_d   = OP_ADD;
            chain_d  = 1'b0;
            last_b_d = BCD_ZERO;
            wait_d   = '0;
            a_clr    = 1'b1;
            b_clr    = 1'b1;
        end
    end

    bcd_entry_reg u_reg_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (a_clr),
        .load_i     (a_load),
        .load_val_i (a_load_val),
        .load_cnt_i (a_load_cnt),
        .shift_i    (a_shift),
        .digit_i    (key_code),
`ifdef CALC_BACKSPACE_EN
        .bs_i       (a_bs),
`endif
        .val_o      (a_val),
        .cnt_o      (a_cnt)
    );

    bcd_entry_reg u_reg_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (b_clr),
        .load_i     (b_load),
        .load_val_i (last_b_q),
        .load_cnt_i (b_cnt),
        .shift_i    (b_shift),
        .digit_i    (key_code),
`ifdef CALC_BACKSPACE_EN
        .bs_i       (b_bs),
`endif
        .val_o      (b_val),
        .cnt_o      (b_cnt)
    );

    always_comb begin
        busy      = (state_q == WAIT_ALU);
        key_ready = (state_q != WAIT_ALU);
        disp_bcd  = (state_q == ENTER_B && b_cnt != 3'd0) ? b_val : a_val;
    end

    assign alu_num1 = a_val;
    assign alu_num2 = b_val;
    assign alu_op   = op_q;

    logic unused_cnt;
    assign unused_cnt = ^a_cnt;

endmodule

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
Keypad-to-ALU sequencer for the 4-digit BCD calculator. It accepts decoded key events and builds operands A and B in BCD. It drives the registered BCD add/sub ALU, waits out the ALU pipeline latency and captures the result. It also supplies the 4-digit value shown on the display, and supports chained operations and repeated '='.

Parameters:
ALU_LAT, 2, clock edges from stable operands to valid alu_result (the ALU has an input stage and an output stage).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  key event present
key_code  in  4  0-9 digit; A '+'; B '-'; C '='; D clear; E backspace; F ignored
key_ready  out  1  controller can accept a key this cycle
alu_num1  out  16  operand A, BCD D3..D0
alu_num2  out  16  operand B, BCD
alu_op  out  2  2'b01 add, 2'b10 sub
alu_result  in  16  ALU result, BCD, saturated 0..9999
disp_bcd  out  16  value to display, BCD
busy  out  1  high while waiting for the ALU

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state ENTER_A.
  - A, B, last_B = 0.
  - cnt_a, cnt_b = 0.
  - op = 2'b01; pending_op = 2'b01; chain = 0.
  - Outputs: alu_num1 = alu_num2 = 0, alu_op = 01, disp_bcd = 0, busy = 0, key_ready = 1.
- A key is accepted only on a cycle with key_valid && key_ready; at most one key per cycle. All outputs are registered or state-decoded; no combinational path from key inputs to outputs.
- Digit entry on register R with count c:
  - If R == 0 and the digit is 0: no change.
  - Else if c == 4: digit ignored, no wrap.
  - Else R <= {R[11:0], d}, c <= c + 1.
- States and transitions:
  - ENTER_A:
    - digit: enter into A.
    - +/-: op <= key; B <= 0; cnt_b <= 0; go to ENTER_B.
    - '=': ignored.
    - clear: A <= 0, cnt_a <= 0.
  - ENTER_B:
    - digit: enter into B.
    - +/- with cnt_b == 0: replace op.
    - +/- with cnt_b > 0: pending_op <= key; chain <= 1; go to WAIT_ALU.
    - '=': chain <= 0; go to WAIT_ALU. If no B digits were entered, B stays 0.
    - clear: all registers return to their reset values; go to ENTER_A.
  - WAIT_ALU:
    - busy = 1, key_ready = 0.
    - A, B and op are held stable.
    - The state lasts exactly ALU_LAT+1 cycles, using a down-counter loaded on entry.
    - On the exit edge: A <= alu_result; last_B <= B; cnt_a <= 4.
    - If chain: op <= pending_op; B <= 0; cnt_b <= 0; go to ENTER_B.
    - Else go to SHOW_RES.
  - SHOW_RES:
    - digit: A <= {12'h000, d}; cnt_a <= (d != 0); go to ENTER_A.
    - +/-: op <= key; B <= 0; cnt_b <= 0; go to ENTER_B, continuing from the result.
    - '=': B <= last_B; go to WAIT_ALU to repeat the last operation (e.g. 5+3== gives 0008 then 0011).
    - clear: reset values; go to ENTER_A.
- Key codes F, and E when backspace is disabled, are accepted and ignored in every state.
- disp_bcd:
  - ENTER_A, WAIT_ALU, SHOW_RES: A.
  - ENTER_B: B when cnt_b > 0, else A.
  - disp_bcd is updated on the same edge as the register it mirrors.
- alu_num1 = A, alu_num2 = B, alu_op = op, all driven directly from registers.
- rst_n asserted during WAIT_ALU aborts the calculation immediately and restores all reset values. A late alu_result is never captured.

Optional Feature:
Macro CALC_BACKSPACE_EN.
- Defined: key E in ENTER_A or ENTER_B, with c > 0, does R <= {4'h0, R[15:4]}, c <= c - 1. With c == 0 it is ignored. Key E in SHOW_RES is ignored.
- Not defined: key E is always ignored, and no backspace logic is synthesized.

Decomposition:
- Package calc_pkg:
  - key code localparams: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_EQ=4'hC, KEY_CLR=4'hD, KEY_BS=4'hE.
  - op codes: OP_ADD=2'b01, OP_SUB=2'b10.
  - state encoding: ENTER_A, ENTER_B, WAIT_ALU, SHOW_RES.
  - BCD_ZERO constant.
- Sub-module bcd_entry_reg, instantiated for A and B:
  - holds the 16-bit BCD value and its 3-bit digit count.
  - inputs: shift-in digit, backspace, clear, parallel load.
  - implements the leading-zero and 4-digit-limit rules.

Test Plan:
- Keys 1,2,+,3,4,= → busy high for exactly 3 cycles (ALU_LAT=2), key_ready low during them; then SHOW_RES with disp_bcd = 16'h0046.
- Keys 5,-,9,= → disp_bcd = 16'h0000 (ALU saturation passed through); then '=' again → 16'h0000; then +,7,= → 16'h0007.
- Keys 9,9,9,9,+,1,= → 16'h9999; keys 1,2,3,4,5 from clear → A = 16'h1234, fifth digit ignored; 0,0,7 → 16'h0007.
- Keys 1,+,2,+,3,= → after the second '+', disp_bcd = 16'h0003 and state ENTER_B with op add; final result 16'h0006. Also +,- with no B digits → op = 2'b10.
- key_valid held high through WAIT_ALU → no key consumed until key_ready returns. rst_n pulsed low mid-WAIT_ALU → all outputs at reset values asynchronously, state ENTER_A.
- With CALC_BACKSPACE_EN: keys 1,2,3,E → A = 16'h0012, cnt_a = 2; E three times → A = 0 and the extra E ignored. Without the macro: E leaves A = 16'h0123.
